// File: rtl/instr_field_splitter_if.sv
// Fetch-to-decode handshake bundle for the instruction field splitter.
// The splitter binds to the slave side; the fetch/decode pair (or a bench) binds to master.
interface instr_field_splitter_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;

    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [2:0]  out_rd;
    logic [2:0]  out_rs1;
    logic [2:0]  out_rs2;
    logic [15:0] out_imm16;
    logic [11:0] out_jump_offset;
    logic [3:0]  out_pc_high;
    logic [15:0] out_pc;
    logic        out_is_jtype;
    logic [15:0] instr_count;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
               out_imm16, out_jump_offset, out_pc_high, out_pc, out_is_jtype,
               instr_count
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
               out_imm16, out_jump_offset, out_pc_high, out_pc, out_is_jtype,
               instr_count
    );
endinterface

// File: rtl/instr_field_splitter.sv
// 2-entry FIFO of {instr, pc} that splits the head word into decode fields; 1-cycle latency.
// in_ready drops only when both entries are held (no same-cycle pop credit); flush empties it.
module instr_field_splitter #(
    parameter logic [3:0] JMP_OPCODE  = 4'hC,
    parameter logic [3:0] CALL_OPCODE = 4'hD,
    parameter bit         IMM_SIGNED  = 1'b1
) (
    input logic                    clk,
    input logic                    reset,
    input logic                    flush,
    instr_field_splitter_if.slave  bus
);

    logic [15:0] instr_q [2];
    logic [15:0] instr_d [2];
    logic [15:0] pc_q    [2];
    logic [15:0] pc_d    [2];
    logic [1:0]  vld_q;
    logic [1:0]  vld_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [15:0] instr_count_q, instr_count_d;

    logic        in_ready;
    logic        out_valid;
    logic        push;
    logic        pop;
    logic        head_show;
    logic [15:0] head_instr;
    logic [15:0] head_pc;
    logic [3:0]  head_opcode;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    always_comb begin
        instr_d       = instr_q;
        pc_d          = pc_q;
        vld_d         = vld_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        instr_count_d = instr_count_q;

        if (flush) begin
            // Handshakes in the flush cycle are dropped, including the delivery count.
            vld_d    = 2'b00;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                instr_d[wr_ptr_q] = bus.in_instr;
                pc_d[wr_ptr_q]    = bus.in_pc;
                vld_d[wr_ptr_q]   = 1'b1;
                wr_ptr_d          = ~wr_ptr_q;
            end
            if (pop) begin
                vld_d[rd_ptr_q] = 1'b0;
                rd_ptr_d        = ~rd_ptr_q;
                instr_count_d   = instr_count_q + 16'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q[0]    <= 16'h0000;
            instr_q[1]    <= 16'h0000;
            pc_q[0]       <= 16'h0000;
            pc_q[1]       <= 16'h0000;
            vld_q         <= 2'b00;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            instr_count_q <= 16'h0000;
        end else begin
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            vld_q         <= vld_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Fields are zeroed whenever there is no valid head so decode never sees stale words.
    assign head_show   = out_valid && vld_q[rd_ptr_q];
    assign head_instr  = head_show ? instr_q[rd_ptr_q] : 16'h0000;
    assign head_pc     = head_show ? pc_q[rd_ptr_q]    : 16'h0000;
    assign head_opcode = head_instr[15:12];

    assign bus.in_ready        = in_ready;
    assign bus.out_valid       = out_valid;
    assign bus.out_opcode      = head_opcode;
    assign bus.out_rd          = head_instr[11:9];
    assign bus.out_rs1         = head_instr[8:6];
    assign bus.out_rs2         = head_instr[5:3];
    assign bus.out_imm16       = IMM_SIGNED ? {{10{head_instr[5]}}, head_instr[5:0]}
                                            : {10'b0, head_instr[5:0]};
    assign bus.out_jump_offset = head_instr[11:0];
    assign bus.out_pc_high     = head_pc[15:12];
    assign bus.out_pc          = head_pc;
    assign bus.out_is_jtype    = head_show &&
                                 ((head_opcode == JMP_OPCODE) || (head_opcode == CALL_OPCODE));
    assign bus.instr_count     = instr_count_q;

endmodule

// File: doc/instr_field_splitter.md
Name: instr_field_splitter

Overview:
Inverse of the jump-address concatenation path in the multicycle 16-bit RISC core. It accepts a fetched 16-bit instruction word plus its 16-bit PC and buffers them in a 2-entry registered FIFO. It splits each word into opcode, register, immediate and 12-bit jump-offset fields, and also splits off PC[15:12] so the downstream concatenation uses the fetch-time high bits. It sits between the fetch stage and the decode/control unit, with valid/ready handshakes on both sides and a synchronous flush for taken branches.

Parameters:
JMP_OPCODE, 4'hC, opcode classified as J-type jump
CALL_OPCODE, 4'hD, opcode classified as J-type call
IMM_SIGNED, 1, 1 = sign-extend imm6 to 16 bits; 0 = zero-extend

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous discard of all buffered entries
in_valid  input  1  fetch presents instr/pc
in_ready  output  1  splitter can accept; asserted when fewer than 2 entries are held
in_instr  input  16  instruction word
in_pc  input  16  PC of in_instr
out_valid  output  1  head entry is valid
out_ready  input  1  decode consumes head entry
out_opcode  output  4  instr[15:12]
out_rd  output  3  instr[11:9]
out_rs1  output  3  instr[8:6]
out_rs2  output  3  instr[5:3]
out_imm16  output  16  instr[5:0] extended per IMM_SIGNED
out_jump_offset  output  12  instr[11:0]
out_pc_high  output  4  pc[15:12] of head entry
out_pc  output  16  full PC of head entry
out_is_jtype  output  1  opcode == JMP_OPCODE or CALL_OPCODE
instr_count  output  16  number of entries delivered since reset

Behaviour:
- Storage: 2 entries of {instr, pc}, with a read pointer, a write pointer and count (0..2). All state is registered; field outputs are combinational from the head entry.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count != 2). It depends only on registered state: a full buffer does not accept, even if a pop occurs in the same cycle.
- out_valid = (count != 0).
- Latency: a word accepted at edge N is visible at outputs with out_valid=1 after edge N (one cycle).
- Order is strictly FIFO. Pointers are 1 bit and wrap 1->0.
- Simultaneous push and pop with count=1: count stays 1, head advances to the new word, and no bubble appears.
- All field outputs (opcode..pc, is_jtype) are forced to 0 while out_valid=0.
- Immediate extension: if IMM_SIGNED=1, out_imm16 = {{10{instr[5]}}, instr[5:0]}; otherwise it is zero-extended.
- instr_count increments by 1 on each pop and wraps 16'hFFFF -> 16'h0000. It is unaffected by flush.
- flush: at the next edge, count, both pointers and the entry valid bits become 0. A push and/or pop in the same cycle is discarded and not counted. in_ready is not gated by flush.
- reset has priority over flush. On reset: count=0, pointers=0, stored entries=0, instr_count=0, out_valid=0, in_ready=1, all field outputs 0.
- Reset mid-transfer: any handshake in the reset cycle is ignored.
- No X propagation: unused storage is reset to 0.

Test Plan:
- Reset, then push in_instr=16'hC123 with in_pc=16'h5A02 and hold out_ready=0 -> after 1 cycle: out_valid=1, opcode=4'hC, jump_offset=12'h123, pc_high=4'h5, is_jtype=1, in_ready=1, instr_count=0.
- Push 16'h4A7F with IMM_SIGNED=1 -> rd=5, rs1=1, rs2=7, imm16=16'hFFFF, is_jtype=0. Repeat with IMM_SIGNED=0 -> imm16=16'h003F.
- Push 3 words back-to-back with out_ready=0 -> in_ready drops to 0 after the 2nd accept. The 3rd is held by fetch. Raising out_ready drains the words in order A, B, C, and instr_count ends at 3.
- Set count=1 and do a simultaneous push and pop every cycle for 8 cycles -> out_valid stays 1, each word appears exactly one cycle, instr_count increases by 8.
- Buffer full, then assert flush together with in_valid and out_ready -> next cycle: out_valid=0, all fields 0, instr_count unchanged, in_ready=1.
- Drive 65536 pops -> instr_count wraps to 0. Assert reset with count=2 -> all outputs return to reset values next cycle.
